// File: rtl/mem_stage_v3_pkg.sv
// rtl/mem_stage_v3_pkg.sv - shared encodings and byte-enable helper for the MEM stage
package mem_stage_v3_pkg;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_W    = 2'b01;
  localparam logic [1:0] ST_H    = 2'b10;
  localparam logic [1:0] ST_B    = 2'b11;

  localparam logic [1:0] LD_W  = 2'b00;
  localparam logic [1:0] LD_HS = 2'b01;
  localparam logic [1:0] LD_BS = 2'b10;
  localparam logic [1:0] LD_BU = 2'b11;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      ST_W:    be = 4'b1111;
      ST_H:    be = lo[1] ? 4'b1100 : 4'b0011;
      ST_B:    be = 4'b0001 << lo;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_v3_if.sv
// rtl/mem_stage_v3_if.sv - EX/MEM inputs and MEM/WB outputs of the memory stage
interface mem_stage_v3_if #(parameter int DATA_WIDTH = 32);

  logic                  iValid;
  logic                  cBranch;
  logic                  cZero;
  logic                  cMemRead;
  logic [1:0]            cMemWrite;
  logic [1:0]            cLoadMode;
  logic                  cRegWrite;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic [DATA_WIDTH-1:0] ReadReg2;
  logic [DATA_WIDTH-1:0] PCPlus4;
  logic [DATA_WIDTH-1:0] PCSumImm;
  logic [4:0]            RegDstResult;

  logic                  oStall;
  logic                  ocPCSrc;
  logic [DATA_WIDTH-1:0] oPCSumImm;
  logic                  oValid;
  logic                  ocRegWrite;
  logic [DATA_WIDTH-1:0] oMemReadData;
  logic [DATA_WIDTH-1:0] oALUResult;
  logic [DATA_WIDTH-1:0] oPCPlus4;
  logic [4:0]            oRegDstResult;
  logic                  oMisaligned;

  modport master (
    output iValid, cBranch, cZero, cMemRead, cMemWrite, cLoadMode, cRegWrite,
           ALUResult, ReadReg2, PCPlus4, PCSumImm, RegDstResult,
    input  oStall, ocPCSrc, oPCSumImm, oValid, ocRegWrite, oMemReadData,
           oALUResult, oPCPlus4, oRegDstResult, oMisaligned
  );

  modport slave (
    input  iValid, cBranch, cZero, cMemRead, cMemWrite, cLoadMode, cRegWrite,
           ALUResult, ReadReg2, PCPlus4, PCSumImm, RegDstResult,
    output oStall, ocPCSrc, oPCSumImm, oValid, ocRegWrite, oMemReadData,
           oALUResult, oPCPlus4, oRegDstResult, oMisaligned
  );

endinterface

// File: rtl/mem_stage_v3_dmem.sv
// rtl/mem_stage_v3_dmem.sv - word-wide data memory, byte-enable write, combinational read
module mem_stage_v3_dmem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // No reset: contents survive a pipeline reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage_v3.sv
// rtl/mem_stage_v3.sv - MEM stage: wait-state FSM, sub-word load/store, MEM/WB register
module mem_stage_v3
  import mem_stage_v3_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int MEM_LATENCY = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  mem_stage_v3_if.slave bus
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LAT_M1 = (MEM_LATENCY > 0) ? CW'(MEM_LATENCY - 1) : '0;

  logic [1:0] addr_lo;
  logic       is_store, is_load, acc, mis_raw, mis, go;
  logic       stall, exec;
  logic [0:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata, rword, ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  logic                  valid_q, valid_d, regwr_q, regwr_d, mis_q, mis_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, alu_q, alu_d, pc4_q, pc4_d;
  logic [4:0]            rd_q, rd_d;

  assign addr_lo  = bus.ALUResult[1:0];
  assign is_store = bus.cMemWrite != ST_NONE;
  assign is_load  = bus.cMemRead & ~is_store;
  assign acc      = bus.iValid & (bus.cMemRead | is_store);

  // Store size wins over load mode when both are requested
  always_comb begin
    mis_raw = 1'b0;
    if (is_store) begin
      case (bus.cMemWrite)
        ST_W:    mis_raw = |addr_lo;
        ST_H:    mis_raw = addr_lo[0];
        default: mis_raw = 1'b0;
      endcase
    end else begin
      case (bus.cLoadMode)
        LD_HS:   mis_raw = addr_lo[0];
        LD_BS,
        LD_BU:   mis_raw = 1'b0;
        default: mis_raw = |addr_lo;
      endcase
    end
  end

  assign mis = acc & mis_raw;
  assign go  = acc & ~mis_raw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    exec    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (MEM_LATENCY == 0) begin
            exec = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = LAT_M1;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          exec    = go;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wdata = bus.ReadReg2;
    case (bus.cMemWrite)
      ST_H:    wdata = {2{bus.ReadReg2[15:0]}};
      ST_B:    wdata = {4{bus.ReadReg2[7:0]}};
      default: wdata = bus.ReadReg2;
    endcase
  end

  mem_stage_v3_dmem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_W     (AW)
  ) u_dmem (
    .clk   (Clk),
    .we    (exec & is_store & Reset),
    .be    (store_be(bus.cMemWrite, addr_lo)),
    .addr  (bus.ALUResult[AW+1:2]),
    .wdata (wdata),
    .rdata (rword)
  );

  always_comb begin
    byte_sel = rword[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (bus.cLoadMode)
      LD_HS:   ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      LD_BS:   ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      LD_BU:   ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      default: ext = rword;
    endcase
  end

  // A stalled cycle hands a bubble to MEM/WB
  always_comb begin
    valid_d = bus.iValid & ~stall;
    regwr_d = bus.cRegWrite & bus.iValid & ~mis & ~stall;
    mis_d   = mis;
    rdata_d = (exec & is_load) ? ext : '0;
    alu_d   = bus.ALUResult;
    pc4_d   = bus.PCPlus4;
    rd_d    = bus.RegDstResult;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      alu_q   <= '0;
      pc4_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      regwr_q <= regwr_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      pc4_q   <= pc4_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.oStall        = stall;
  assign bus.ocPCSrc       = bus.iValid & bus.cBranch & bus.cZero;
  assign bus.oPCSumImm     = bus.PCSumImm;
  assign bus.oValid        = valid_q;
  assign bus.ocRegWrite    = regwr_q;
  assign bus.oMisaligned   = mis_q;
  assign bus.oMemReadData  = rdata_q;
  assign bus.oALUResult    = alu_q;
  assign bus.oPCPlus4      = pc4_q;
  assign bus.oRegDstResult = rd_q;

endmodule
